// File: rtl/dsp_arbiter.sv
// dsp_arbiter: round-robin arbiter sharing one pipelined MAC datapath among four requesters
module dsp_arbiter #(
   parameter int PIPE_LAT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    req_valid,
   output logic [3:0]    req_ready,
   input  logic [71:0]   req_a,
   input  logic [71:0]   req_b,
   input  logic [71:0]   req_d,
   input  logic [191:0]  req_c,
   input  logic [3:0]    req_op,
   input  logic          drain,
   output logic [17:0]   dsp_a,
   output logic [17:0]   dsp_b,
   output logic [17:0]   dsp_d,
   output logic [47:0]   dsp_c,
   output logic          dsp_op,
   output logic          dsp_issue,
   input  logic [47:0]   dsp_p,
   output logic          res_valid,
   output logic [1:0]    res_id,
   output logic [47:0]   res_data,
   output logic          idle
);
   logic [1:0]                rr;
   logic [1:0]                gid;
   logic [1:0]                idx;
   logic [1:0]                issue_id;
   logic                      hs;
   logic [PIPE_LAT-1:0]       tv;
   logic [PIPE_LAT-1:0][1:0]  tid;

   // first valid requester at or after rr wins; drain and reset block every grant
   always_comb begin
      req_ready = '0;
      gid = '0;
      idx = '0;
      for (int k = 3; k >= 0; k--) begin
         idx = rr + 2'(k);
         if (req_valid[idx]) begin
            req_ready = 4'b0001 << idx;
            gid = idx;
         end
      end
      if (drain || !rst_n) req_ready = '0;
   end

   assign hs = |req_ready;

   // capture the granted requester's operands and advance the round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr <= '0;
         issue_id <= '0;
         dsp_issue <= 1'b0;
         dsp_a <= '0;
         dsp_b <= '0;
         dsp_d <= '0;
         dsp_c <= '0;
         dsp_op <= 1'b0;
      end else begin
         dsp_issue <= hs;
         if (hs) begin
            rr <= gid + 2'd1;
            issue_id <= gid;
            dsp_a <= req_a[18*gid +: 18];
            dsp_b <= req_b[18*gid +: 18];
            dsp_d <= req_d[18*gid +: 18];
            dsp_c <= req_c[48*gid +: 48];
            dsp_op <= req_op[gid];
         end
      end
   end

   // tag shift register tracks owner of each operation through the datapath latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tv <= '0;
         tid <= '0;
      end else begin
         tv[0] <= dsp_issue;
         tid[0] <= issue_id;
         for (int k = 1; k < PIPE_LAT; k++) begin
            tv[k] <= tv[k-1];
            tid[k] <= tid[k-1];
         end
      end
   end

   // sample the datapath result when its tag leaves the pipeline; hold otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_id <= '0;
         res_data <= '0;
      end else begin
         res_valid <= tv[PIPE_LAT-1];
         if (tv[PIPE_LAT-1]) begin
            res_id <= tid[PIPE_LAT-1];
            res_data <= dsp_p;
         end
      end
   end

   assign idle = !hs && !dsp_issue && !(|tv);
endmodule

// File: doc/dsp_arbiter.md
DSP_ARBITER -- requirements
Module: dsp_arbiter

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 4: cycles from dsp_issue high to the matching dsp_p being valid (legal range 1..8).
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  4  per-requester request valid; requester i uses bit i.
REQ-005 SHALL have port req_ready  output  4  per-requester grant; at most one bit high per cycle.
REQ-006 SHALL have port req_a  input  72  packed operand A; requester i uses bits [18i+17:18i].
REQ-007 SHALL have port req_b  input  72  packed operand B, packed the same way as req_a.
REQ-008 SHALL have port req_d  input  72  packed operand D, packed the same way as req_a.
REQ-009 SHALL have port req_c  input  192  packed operand C; requester i uses bits [48i+47:48i].
REQ-010 SHALL have port req_op  input  4  per-requester operation select: 0 = add, 1 = subtract.
REQ-011 SHALL have port drain  input  1  stop accepting new requests.
REQ-012 SHALL have ports dsp_a, dsp_b, dsp_d  output  18 each  registered operands to the MAC datapath.
REQ-013 SHALL have port dsp_c  output  48  registered C operand.
REQ-014 SHALL have port dsp_op  output  1  registered operation select.
REQ-015 SHALL have port dsp_issue  output  1  a new operand set is presented this cycle.
REQ-016 SHALL have port dsp_p  input  48  datapath result.
REQ-017 SHALL have port res_valid  output  1  result strobe; single cycle, no backpressure.
REQ-018 SHALL have port res_id  output  2  index of the requester that owns the result.
REQ-019 SHALL have port res_data  output  48  result value.
REQ-020 SHALL have port idle  output  1  nothing accepted, issued or in flight.

Function
REQ-021 Grant: req_ready[i] is combinational, from req_valid and the round-robin pointer; handshake on requester i = req_valid[i] & req_ready[i].
REQ-022 Round-robin: search starts at pointer rr and wraps through 3..0; after a handshake on requester i, rr = (i+1) mod 4; rr is unchanged when no handshake occurs.
REQ-023 drain=1 forces req_ready = 0 in that same cycle; operations already accepted or in flight complete normally.
REQ-024 Handshake in cycle T-1: in cycle T, dsp_a/b/c/d/op hold requester i's operands and dsp_issue = 1; otherwise dsp_issue = 0 and the operand outputs hold their previous values.
REQ-025 Back-to-back issue is allowed every cycle; throughput is one operation per clock.
REQ-026 Tag pipeline: a PIPE_LAT-deep shift register of {valid, id} advances every cycle; a tag enters on each dsp_issue.
REQ-027 When the tag for a dsp_issue in cycle T exits, dsp_p is sampled in cycle T+PIPE_LAT.
REQ-028 In cycle T+PIPE_LAT+1: res_valid = 1, res_id = owning requester, res_data = the sampled dsp_p.
REQ-029 Total latency from handshake to res_valid is PIPE_LAT+2 cycles; results return in issue order.
REQ-030 When res_valid = 0, res_data and res_id hold their previous values.
REQ-031 idle = 1 iff no bit of req_ready is high, dsp_issue = 0, and no tag is valid.
REQ-032 A requester may hold req_valid with changing operands; only the operands present in the handshake cycle are used.

Reset
REQ-033 rst_n low clears immediately: req_ready = 0, dsp_* = 0, dsp_issue = 0, res_valid = 0, res_id = 0, res_data = 0, rr = 0, all tags invalid, idle = 1.
REQ-034 Reset mid-operation discards all in-flight tags; no res_valid is produced for them after reset releases.
REQ-035 First grant is possible in the first cycle after rst_n deasserts.

Verification
REQ-036 All four requesters valid continuously, PIPE_LAT=4 -> grants are 0,1,2,3,0,... one per cycle; res_id follows the same sequence starting 6 cycles after the first handshake.
REQ-037 Requester 2 alone, A=3, B=4, D=5, C=10, op=0, with a reference datapath connected -> res_valid after 6 cycles, res_id = 2, res_data = 3*(5+4)+10 = 37.
REQ-038 Requesters 1 and 3 valid, rr = 2 -> grant 3 first, then 1, then 3.
REQ-039 drain raised while 3 operations are in flight -> req_ready = 0 immediately; 3 results are delivered, then idle = 1.
REQ-040 rst_n pulsed low while 2 tags are in flight -> outputs 0 asynchronously, idle = 1, no res_valid after release.
